memory_access: RTL and testbench
================================

# memory_access

Memory-stage data access unit for the pipelined RISC-V core. It turns the M-stage load/store controls into a valid/ready request on the data bus and byte-aligns store data into lanes with strobes. For loads, it waits for the bus response, then aligns and sign- or zero-extends the returned word into `ReadDataM`; that value is the load result carried into write-back. It stalls the pipeline while any access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: bus address width.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `MemReadM`  in  1  M-stage instruction is a load.
- `MemWriteM`  in  1  M-stage instruction is a store; never asserted together with `MemReadM`.
- `Funct3M`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- `ALUResultM`  in  32  effective byte address.
- `WriteDataM`  in  32  store data, right-justified.
- `ReadDataM`  out  32  aligned, extended load data; valid in DONE.
- `StallM`  out  1  freezes F/D/E/M pipeline registers.
- `MisalignM`  out  1  misaligned-access flag, one-cycle pulse.
- `bus_valid`  out  1  request valid.
- `bus_ready`  in  1  request accepted.
- `bus_we`  out  1  1 for a store.
- `bus_addr`  out  ADDR_W  word-aligned address (`addr[1:0]` = 0).
- `bus_wdata`  out  32  lane-shifted store data.
- `bus_wstrb`  out  4  byte strobes.
- `bus_rvalid`  in  1  read response valid.
- `bus_rdata`  in  32  read response word.

## Operation
- FSM states: IDLE, REQ, WAIT_RESP, DONE. Reset state is IDLE.
- IDLE, with a load or store that is not misaligned:
  - Drive `bus_valid`.
  - Go to WAIT_RESP if the access is a load and `bus_ready` is high.
  - Go to DONE if the access is a store and `bus_ready` is high.
  - Go to REQ if `bus_ready` is low.
- REQ: hold `bus_valid`, `bus_we`, `bus_addr`, `bus_wdata` and `bus_wstrb` from registered copies; they must not change until `bus_ready`. On `bus_ready`, go to WAIT_RESP (load) or DONE (store).
- WAIT_RESP: `bus_valid` is low. On `bus_rvalid`, capture the aligned and extended data into the `ReadDataM` register and go to DONE.
- DONE: lasts exactly one cycle with `StallM` low so the instruction advances, then returns to IDLE. No request is issued in DONE, so the same instruction is never reissued.
- `StallM` = (IDLE and a valid access is pending) or REQ or WAIT_RESP. It is combinational from the M-stage inputs.
- Store lanes:
  - B: strobe `1 << a[1:0]`; the data byte is replicated to all lanes.
  - H: strobe `0011 << a[1:0]`; the halfword is replicated to both halves.
  - W: strobe 1111.
- Load: shift the word right by `a[1:0]*8`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Alignment and size use the address offset and `Funct3M` registered at request issue, not the live inputs.
- `bus_rvalid` outside WAIT_RESP is ignored.
- Reset mid-access: immediate return to IDLE, `bus_valid` low, any in-flight response discarded. The bus is reset by the same `reset_n`.

## Timing
- Reset values: `ReadDataM` 0, `StallM` 0, `MisalignM` 0, `bus_valid` 0, `bus_we` 0, `bus_addr` 0, `bus_wdata` 0, `bus_wstrb` 0.
- Store with `bus_ready` high at issue: 1 stall cycle, DONE in the next cycle.
- Load with `bus_ready` high at issue and `bus_rvalid` high on the following cycle: 2 stall cycles; data is in `ReadDataM` in DONE, the third cycle.
- Each cycle of `bus_ready` low adds one stall cycle. Each cycle of response delay adds one stall cycle.
- `bus_rvalid` may arrive no earlier than the cycle after acceptance.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A misaligned access is H with `a[0]`=1, or W with `a[1:0]`≠0.
  - It issues no bus request.
  - `MisalignM` pulses for one cycle in IDLE, and `StallM` stays low.
- `MISALIGN_TRAP_EN` undefined:
  - `MisalignM` is tied 0.
  - A misaligned access clears the offending low bits (H: `a[0]`, W: `a[1:0]`) and proceeds as an aligned access.

## Structure
- `mem_pkg` holds the `Funct3M` encodings as a typedef enum, the FSM state enum, and a strobe-lookup function.
- One sub-module, `load_extend`: combinational shift plus sign/zero extension, taking offset, `Funct3M` and the raw word. It is instantiated once, ahead of the `ReadDataM` register.

## Test plan
- SW at 0x100 with `WriteDataM`=0xDEADBEEF and `bus_ready`=1 → `bus_addr`=0x100, `bus_wstrb`=1111; `StallM` high for 1 cycle, DONE next.
- LB at 0x203, `bus_rdata`=0x80112233, response one cycle after accept → `ReadDataM`=0xFFFFFF80. LBU at the same address and data → 0x00000080.
- SH at 0x102 with `bus_ready` low for 3 cycles → `bus_wstrb`=1100 and request fields stable throughout; `StallM` high for 4 cycles.
- LW at 0x202, trap enabled → no `bus_valid`, `MisalignM`=1 for one cycle, `StallM`=0. Trap disabled → `bus_addr`=0x200.
- Assert `reset_n` low during WAIT_RESP, then drive a stray `bus_rvalid` → state IDLE, all outputs at reset values, `ReadDataM` stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory-access unit: Funct3 load/store encodings, FSM states
// and the byte-strobe lookup used when placing store data into lanes.
package mem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RESP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  // Unlisted Funct3 codes fall through to word size.
  function automatic size_e size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = SZ_B;
      2'b01:   size_of = SZ_H;
      default: size_of = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] strb_lookup(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    strb_lookup = 4'b0001 << off;
      SZ_H:    strb_lookup = 4'b0011 << off;
      default: strb_lookup = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// load_extend: shifts a returned bus word down to the accessed byte offset and
// sign- or zero-extends it according to the load's Funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_e'(funct3_i))
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// M-stage data access unit: valid/ready bus requests, store lane placement and
// load alignment/extension. Define MISALIGN_TRAP_EN to flag misaligned accesses.
module memory_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              MisalignM,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  state_e            state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [31:0]       rdata_q;

  logic              access;
  logic              trap;
  logic              issue;
  size_e             live_sz;
  logic [1:0]        raw_off;
  logic [1:0]        live_off;
  logic [ADDR_W-1:0] live_addr;
  logic [31:0]       live_wdata;
  logic [3:0]        live_strb;
  logic [31:0]       ext_data;

  assign access    = MemReadM | MemWriteM;
  assign live_sz   = size_of(Funct3M);
  assign raw_off   = ALUResultM[1:0];
  assign live_addr = ADDR_W'({ALUResultM[31:2], 2'b00});

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((live_sz == SZ_H) && raw_off[0]) ||
                    ((live_sz == SZ_W) && (raw_off != 2'b00));
  assign trap     = access & misalign;
`else
  assign trap     = 1'b0;
`endif

  assign issue = access & ~trap;

  // Offending low address bits are dropped so a misaligned access behaves aligned.
  always_comb begin
    live_off   = raw_off;
    live_wdata = WriteDataM;
    case (live_sz)
      SZ_B: begin
        live_off   = raw_off;
        live_wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        live_off   = {raw_off[1], 1'b0};
        live_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        live_off   = 2'b00;
        live_wdata = WriteDataM;
      end
    endcase
  end

  assign live_strb = strb_lookup(live_sz, live_off);

  load_extend u_load_extend (
    .off_i    (off_q),
    .funct3_i (f3_q),
    .word_i   (bus_rdata),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request copies are taken at issue so REQ/WAIT_RESP ignore the live M-stage inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && issue) begin
        we_q    <= MemWriteM;
        addr_q  <= live_addr;
        wdata_q <= MemWriteM ? live_wdata : 32'h0;
        strb_q  <= MemWriteM ? live_strb : 4'h0;
        f3_q    <= Funct3M;
        off_q   <= live_off;
      end
      if (state_q == S_WAIT_RESP && bus_rvalid) begin
        rdata_q <= ext_data;
      end
    end
  end

  assign ReadDataM = rdata_q;

  always_comb begin
    state_d   = state_q;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    case (state_q)
      S_IDLE: begin
        MisalignM = trap;
        if (issue) begin
          StallM    = 1'b1;
          bus_valid = 1'b1;
          bus_we    = MemWriteM;
          bus_addr  = live_addr;
          bus_wdata = MemWriteM ? live_wdata : 32'h0;
          bus_wstrb = MemWriteM ? live_strb : 4'h0;
          if (!bus_ready) begin
            state_d = S_REQ;
          end else if (MemWriteM) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_RESP;
          end
        end
      end
      S_REQ: begin
        StallM    = 1'b1;
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        bus_wstrb = strb_q;
        if (bus_ready) begin
          state_d = we_q ? S_DONE : S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        StallM = 1'b1;
        if (bus_rvalid) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with a transaction-level reference model and a
// per-cycle compare process. Honours MISALIGN_TRAP_EN like the design.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  memory_access #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        exp_stall, exp_mis, exp_valid, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_strb;
  logic [31:0] model_rd;
  int          stall_cnt, valid_cnt, mis_cnt;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_strb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sizes, lanes and extension from plain arithmetic
  function automatic int sz_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = sz_bytes(f3);
    return (sz > 1) && ((a % sz) != 0);
  endfunction

  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [31:0] a);
    int o;
    o = a % 4;
    return 2'(o - (o % sz_bytes(f3)));
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] off);
    return 4'(((1 << sz_bytes(f3)) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    int sz;
    sz = sz_bytes(f3);
    if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] v;
    int sz;
    sz = sz_bytes(f3);
    v  = w >> (8 * off);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Compare process: every cycle, outputs against the model expectations
  always @(negedge clk) begin
    chk("StallM", StallM, exp_stall);
    chk("MisalignM", MisalignM, exp_mis);
    chk("bus_valid", bus_valid, exp_valid);
    chk("bus_we", bus_we, exp_we);
    chk("bus_addr", bus_addr, exp_addr);
    chk("bus_wdata", bus_wdata, exp_wdata);
    chk("bus_wstrb", bus_wstrb, exp_strb);
    chk("ReadDataM", ReadDataM, model_rd);
    if (StallM === 1'b1) stall_cnt++;
    if (MisalignM === 1'b1) mis_cnt++;
    if (bus_valid === 1'b1) begin
      valid_cnt++;
      obs_addr  = bus_addr;
      obs_wdata = bus_wdata;
      obs_strb  = bus_wstrb;
    end
  end

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_mis = 1'b0; exp_valid = 1'b0; exp_we = 1'b0;
    exp_addr  = '0;   exp_wdata = '0; exp_strb = '0;
  endtask

  task automatic clear_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = '0; WriteDataM = '0; bus_ready = 1'b0;
    bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    set_idle_exp();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int rdy_dly, input int resp_dly,
                           input logic [31:0] rd);
    logic [1:0] off;
    bit trap;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = is_mis(f3, a);
`endif
    off = eff_off(f3, a);
    stall_cnt = 0; valid_cnt = 0; mis_cnt = 0;
    obs_addr = 'x; obs_wdata = 'x; obs_strb = 'x;
    MemReadM = ld; MemWriteM = !ld; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    bus_rvalid = 1'b0;
    if (trap) begin
      set_idle_exp();
      exp_mis = 1'b1;
      @(posedge clk); #1;
      idle(1);
      return;
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      bus_ready = (k == rdy_dly);
      exp_stall = 1'b1; exp_mis = 1'b0; exp_valid = 1'b1; exp_we = !ld;
      exp_addr  = a & 32'hFFFF_FFFC;
      exp_wdata = ld ? 32'h0 : model_wdata(f3, wd);
      exp_strb  = ld ? 4'h0 : model_strb(f3, off);
      @(posedge clk); #1;
      bus_ready = 1'b0;
      // frozen pipeline is not trusted: disturb the live inputs
      ALUResultM = ~a; WriteDataM = ~wd; Funct3M = f3 ^ 3'b011;
    end
    if (ld) begin
      for (int j = 0; j <= resp_dly; j++) begin
        set_idle_exp();
        exp_stall  = 1'b1;
        bus_rvalid = (j == resp_dly);
        bus_rdata  = (j == resp_dly) ? rd : 32'hA5A5_5A5A;
        @(posedge clk); #1;
      end
      bus_rvalid = 1'b0;
      model_rd = model_load(f3, off, rd);
    end
    set_idle_exp();
    @(posedge clk); #1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    model_rd = '0;
    clear_inputs();
    set_idle_exp();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);

    // SW 0x100, ready at issue
    do_access(1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
    chk("sw_stall_cycles", stall_cnt, 1);
    chk("sw_addr", obs_addr, 32'h100);
    chk("sw_strb", obs_strb, 4'b1111);
    chk("sw_wdata", obs_wdata, 32'hDEAD_BEEF);

    // LB / LBU at 0x203
    do_access(1'b1, 3'b000, 32'h203, 0, 0, 0, 32'h8011_2233);
    chk("lb_data", ReadDataM, 32'hFFFF_FF80);
    chk("lb_stall_cycles", stall_cnt, 2);
    do_access(1'b1, 3'b100, 32'h203, 0, 0, 0, 32'h8011_2233);
    chk("lbu_data", ReadDataM, 32'h0000_0080);

    // SH 0x102 with ready held low for 3 cycles
    do_access(1'b0, 3'b001, 32'h102, 32'h0000_1234, 3, 0, 0);
    chk("sh_strb", obs_strb, 4'b1100);
    chk("sh_wdata", obs_wdata, 32'h1234_1234);
    chk("sh_stall_cycles", stall_cnt, 4);

    // SB lane replication, LH signed, LHU, LW with both delays
    do_access(1'b0, 3'b000, 32'h101, 32'h0000_00A5, 1, 0, 0);
    chk("sb_strb", obs_strb, 4'b0010);
    chk("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
    do_access(1'b1, 3'b001, 32'h206, 0, 0, 1, 32'h8001_7FFF);
    chk("lh_data", ReadDataM, 32'hFFFF_8001);
    do_access(1'b1, 3'b101, 32'h200, 0, 1, 0, 32'hABCD_F234);
    chk("lhu_data", ReadDataM, 32'h0000_F234);
    do_access(1'b1, 3'b010, 32'h300, 0, 2, 2, 32'h1357_9BDF);
    chk("lw_data", ReadDataM, 32'h1357_9BDF);
    chk("lw_stall_cycles", stall_cnt, 6);

    // stray response while idle is ignored
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    idle(1);
    chk("stray_rvalid_idle", ReadDataM, 32'h1357_9BDF);

    // LW at 0x202: misaligned
    do_access(1'b1, 3'b010, 32'h202, 0, 0, 0, 32'hCAFE_F00D);
`ifdef MISALIGN_TRAP_EN
    chk("mis_pulse_cycles", mis_cnt, 1);
    chk("mis_valid_cycles", valid_cnt, 0);
    chk("mis_stall_cycles", stall_cnt, 0);
`else
    chk("mis_addr", obs_addr, 32'h200);
    chk("mis_data", ReadDataM, 32'hCAFE_F00D);
    chk("mis_pulse_cycles", mis_cnt, 0);
`endif

    // reset during WAIT_RESP, then a stray response
    MemReadM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h210; bus_ready = 1'b1;
    exp_stall = 1'b1; exp_mis = 1'b0; exp_valid = 1'b1; exp_we = 1'b0;
    exp_addr = 32'h210; exp_wdata = '0; exp_strb = '0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    clear_inputs();
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    model_rd = '0;
    set_idle_exp();
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    stall_cnt = 0;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    idle(2);
    chk("reset_readdata", ReadDataM, 32'h0);
    chk("reset_no_stall", stall_cnt, 0);

    // normal operation after reset
    do_access(1'b0, 3'b010, 32'h400, 32'h0BAD_F00D, 0, 0, 0);
    chk("post_reset_sw_stall", stall_cnt, 1);
    chk("post_reset_sw_addr", obs_addr, 32'h400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
